// File: rtl/bp_gshare.sv
// bp_gshare: gshare branch direction predictor with post-reset table init sweep
// Ports: clk/rst_n (async active-low); ready high once the sweep is done;
// lk_valid/lk_pc -> pred_valid/pred_taken/pred_idx/pred_hist one cycle later;
// upd_valid/upd_idx/upd_taken train a counter, upd_mispredict/upd_hist repair ghr;
// ghr exposes the speculative global history.
module bp_gshare #(
    parameter int IDX_W    = 8,
    parameter int CTR_W    = 2,
    parameter int HIST_W   = 8,
    parameter int INIT_CTR = (1 << (CTR_W - 1)) - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ready,
    input  logic              lk_valid,
    input  logic [IDX_W-1:0]  lk_pc,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [IDX_W-1:0]  pred_idx,
    output logic [HIST_W-1:0] pred_hist,
    input  logic              upd_valid,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic              upd_taken,
    input  logic              upd_mispredict,
    input  logic [HIST_W-1:0] upd_hist,
    output logic [HIST_W-1:0] ghr
);
    typedef enum logic {S_INIT, S_RUN} state_t;
    localparam int N = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT_CTR);
    state_t state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d, idx, wr_idx;
    logic [CTR_W-1:0] tbl [N];
    logic [CTR_W-1:0] c, cur, wr_data;
    logic [HIST_W-1:0] ghr_d;
    logic run, wr_en, lk, repair;
    assign run = state_q == S_RUN;
    assign ready = run;
    assign lk = run && lk_valid;
    assign repair = run && upd_valid && upd_mispredict;
    assign idx = lk_pc ^ IDX_W'(ghr);
    assign c = tbl[idx];
    assign cur = tbl[upd_idx];
    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        if (!run) begin
            ptr_d = ptr_q + IDX_W'(1);
            if (&ptr_q) state_d = S_RUN;
        end
    end
    // One table write per cycle: the sweep owns the port in INIT, training in RUN.
    // Truncating {history, bit} to HIST_W drops the MSB, which also covers HIST_W=1.
    always_comb begin
        wr_en = !run || upd_valid;
        wr_idx = run ? upd_idx : ptr_q;
        wr_data = !run ? CTR_INIT :
                  upd_taken ? (cur == CTR_MAX ? cur : cur + CTR_W'(1)) :
                  (cur == '0 ? cur : cur - CTR_W'(1));
        ghr_d = repair ? HIST_W'({upd_hist, upd_taken}) :
                lk ? HIST_W'({ghr, c[CTR_W-1]}) : ghr;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            ptr_q <= '0;
            ghr <= '0;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_idx <= '0;
            pred_hist <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            ghr <= ghr_d;
            pred_valid <= lk;
            if (lk) begin
                pred_taken <= c[CTR_W-1];
                pred_idx <= idx;
                pred_hist <= ghr;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) tbl[wr_idx] <= wr_data;
    end
endmodule

// File: tb/tb_bp_gshare.sv
// tb_bp_gshare: directed bench for bp_gshare with a cycle-level reference model
module tb_bp_gshare;
    logic clk, rst_n, ready, lk_valid, pred_valid, pred_taken;
    logic upd_valid, upd_taken, upd_mispredict;
    logic [7:0] lk_pc, pred_idx, pred_hist, upd_idx, upd_hist, ghr;
    int n_tests = 0, n_fail = 0, n;
    bit chk = 0;
    int mtab [256];
    int m_ready, m_cnt, m_ghr, e_pv, e_pt, e_pidx, e_phist;

    bp_gshare dut (
        .clk(clk), .rst_n(rst_n), .ready(ready),
        .lk_valid(lk_valid), .lk_pc(lk_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_idx(pred_idx), .pred_hist(pred_hist),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict), .upd_hist(upd_hist), .ghr(ghr)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reference model: counters as plain ints, history as an int modulo 256.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready = 0; m_cnt = 0; m_ghr = 0;
            e_pv = 0; e_pt = 0; e_pidx = 0; e_phist = 0;
        end else if (!m_ready) begin
            mtab[m_cnt] = 1;
            m_cnt++;
            m_ready = (m_cnt == 256) ? 1 : 0;
            e_pv = 0;
        end else begin
            int idx, cval, nghr;
            idx = int'(lk_pc) ^ m_ghr;
            cval = mtab[idx];
            nghr = m_ghr;
            e_pv = lk_valid ? 1 : 0;
            if (lk_valid) begin
                e_pt = (cval >= 2) ? 1 : 0;
                e_pidx = idx;
                e_phist = m_ghr;
                nghr = (m_ghr * 2 + e_pt) % 256;
            end
            if (upd_valid) begin
                if (upd_taken) mtab[upd_idx] = (mtab[upd_idx] + 1 > 3) ? 3 : mtab[upd_idx] + 1;
                else mtab[upd_idx] = (mtab[upd_idx] - 1 < 0) ? 0 : mtab[upd_idx] - 1;
                if (upd_mispredict) nghr = (int'(upd_hist) * 2 + int'(upd_taken)) % 256;
            end
            m_ghr = nghr;
        end
    end

    always @(negedge clk) begin
        if (chk) begin
            check("ready", ready, m_ready);
            check("pred_valid", pred_valid, e_pv);
            check("pred_taken", pred_taken, e_pt);
            check("pred_idx", pred_idx, e_pidx);
            check("pred_hist", pred_hist, e_phist);
            check("ghr", ghr, m_ghr);
        end
    end

    initial begin
        rst_n = 0; lk_valid = 0; lk_pc = 0; upd_valid = 0; upd_idx = 0;
        upd_taken = 0; upd_mispredict = 0; upd_hist = 0;
        repeat (3) step();
        chk = 1;
        rst_n = 1;
        n = 0;
        while (!ready && n < 400) begin step(); n++; end
        check("ready_latency", n, 256);
        for (int pc = 0; pc < 256; pc++) begin
            lk_valid = 1; lk_pc = 8'(pc);
            step();
            if (pc % 64 == 0) check("sweep_pred", pred_taken, 0);
        end
        lk_valid = 0;
        step();
        check("ghr_after_sweep", ghr, 0);

        upd_valid = 1; upd_idx = 8'h05; upd_taken = 1;
        repeat (3) step();
        upd_valid = 0; lk_valid = 1; lk_pc = 8'h05;
        step();
        lk_valid = 0;
        check("sat_hi_taken", pred_taken, 1);
        check("sat_hi_idx", pred_idx, 8'h05);
        check("sat_hi_ghr", ghr, 8'h01);
        upd_valid = 1; upd_taken = 0;
        repeat (4) step();
        upd_valid = 0; lk_valid = 1; lk_pc = 8'h04;
        step();
        lk_valid = 0;
        check("sat_lo_taken", pred_taken, 0);
        check("sat_lo_idx", pred_idx, 8'h05);
        check("sat_lo_ghr", ghr, 8'h02);

        lk_valid = 1; lk_pc = 8'h12; upd_valid = 1; upd_idx = 8'h10; upd_taken = 1;
        step();
        upd_valid = 0;
        check("nobypass_taken", pred_taken, 0);
        check("nobypass_idx", pred_idx, 8'h10);
        lk_pc = 8'h14;
        step();
        lk_valid = 0;
        check("after_upd_taken", pred_taken, 1);
        check("after_upd_ghr", ghr, 8'h09);

        upd_valid = 1; upd_idx = 8'h33; upd_taken = 1; upd_mispredict = 1; upd_hist = 8'h52;
        step();
        upd_valid = 0; upd_mispredict = 0;
        check("repair_ghr", ghr, 8'hA5);
        lk_valid = 1; lk_pc = 8'h0F;
        step();
        lk_valid = 0;
        check("xor_idx", pred_idx, 8'hAA);
        check("xor_hist", pred_hist, 8'hA5);
        check("xor_ghr", ghr, 8'h4A);

        lk_valid = 1; lk_pc = 8'h5A;
        upd_valid = 1; upd_idx = 8'h20; upd_taken = 1; upd_mispredict = 1; upd_hist = 8'h3C;
        step();
        lk_valid = 0; upd_valid = 0; upd_mispredict = 0;
        check("prio_ghr", ghr, 8'h79);
        check("prio_pv", pred_valid, 1);
        check("prio_pt", pred_taken, 1);
        check("prio_hist", pred_hist, 8'h4A);
        step();
        check("idle_pv", pred_valid, 0);
        check("hold_idx", pred_idx, 8'h10);

        rst_n = 0;
        #1;
        check("rst_ready", ready, 0);
        check("rst_pv", pred_valid, 0);
        check("rst_pt", pred_taken, 0);
        check("rst_idx", pred_idx, 0);
        check("rst_hist", pred_hist, 0);
        check("rst_ghr", ghr, 0);
        step();
        rst_n = 1;
        repeat (100) step();
        rst_n = 0;
        #1;
        check("midsweep_ready", ready, 0);
        check("midsweep_ghr", ghr, 0);
        step();
        rst_n = 1;
        lk_valid = 1; lk_pc = 8'h07;
        upd_valid = 1; upd_idx = 8'h07; upd_taken = 1; upd_mispredict = 1; upd_hist = 8'hFF;
        n = 0;
        while (!ready && n < 400) begin step(); n++; end
        lk_valid = 0; upd_valid = 0; upd_mispredict = 0;
        check("resweep_latency", n, 256);
        for (int pc = 0; pc < 100; pc++) begin
            lk_valid = 1; lk_pc = 8'(pc);
            step();
        end
        lk_pc = 8'h10;
        step();
        lk_valid = 0;
        check("reinit_10", pred_taken, 0);
        upd_valid = 1; upd_idx = 8'h05; upd_taken = 1;
        step();
        upd_valid = 0; lk_valid = 1; lk_pc = 8'h05;
        step();
        lk_valid = 0;
        check("reinit_05", pred_taken, 1);
        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
